// File: rtl/imm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : imm_pkg
//  Description : Shared constants for the immediate-generation stage.
//                It holds the format codes, the base opcodes that the decoder
//                recognises and the skid-buffer occupancy states.
//  Revision    : 1.0 - initial release
// ============================================================================
package imm_pkg;

    // Format codes carried on out_fmt
    localparam logic [2:0] FMT_R   = 3'd0;
    localparam logic [2:0] FMT_I   = 3'd1;
    localparam logic [2:0] FMT_ISH = 3'd2;
    localparam logic [2:0] FMT_S   = 3'd3;
    localparam logic [2:0] FMT_B   = 3'd4;
    localparam logic [2:0] FMT_U   = 3'd5;
    localparam logic [2:0] FMT_J   = 3'd6;
    localparam logic [2:0] FMT_ILL = 3'd7;

    // Base opcodes (instr[6:0])
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_OP       = 7'b0110011;

    // Skid-buffer occupancy
    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_TWO   = 2'd2
    } skid_state_t;

endpackage
`default_nettype wire

// File: rtl/imm_decode.sv
`default_nettype none
// ============================================================================
//  Module      : imm_decode
//  Description : Combinational immediate decoder. Derives the instruction
//                format from the opcode and builds the XLEN-wide immediate.
//  Ports       : instr   - 32-bit instruction word
//                fmt     - format code (imm_pkg FMT_*)
//                imm     - extended immediate
//                illegal - opcode not recognised
//                pc_rel  - immediate is PC-relative (branch, JAL, AUIPC)
//  Revision    : 1.0 - initial release
// ============================================================================
module imm_decode
    import imm_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic [31:0]     instr,
    output logic [2:0]      fmt,
    output logic [XLEN-1:0] imm,
    output logic            illegal,
    output logic            pc_rel
);

    logic [6:0] w_opcode;
    logic [2:0] w_funct3;

    assign w_opcode = instr[6:0];
    assign w_funct3 = instr[14:12];

    always_comb begin
        fmt = FMT_ILL;
        case (w_opcode)
            OPC_OP_IMM: begin
                // slli / srli / srai carry a shift amount, not a signed immediate
                if (w_funct3 == 3'b001 || w_funct3 == 3'b101)
                    fmt = FMT_ISH;
                else
                    fmt = FMT_I;
            end
            OPC_LOAD, OPC_JALR, OPC_MISC_MEM, OPC_SYSTEM: fmt = FMT_I;
            OPC_STORE:                                    fmt = FMT_S;
            OPC_BRANCH:                                   fmt = FMT_B;
            OPC_LUI, OPC_AUIPC:                           fmt = FMT_U;
            OPC_JAL:                                      fmt = FMT_J;
            OPC_OP:                                       fmt = FMT_R;
            default:                                      fmt = FMT_ILL;
        endcase
    end

    always_comb begin
        imm = '0;
        case (fmt)
            FMT_I:   imm = {{(XLEN-11){instr[31]}}, instr[30:20]};
            FMT_ISH: imm = {{(XLEN-SHW){1'b0}}, instr[20+SHW-1:20]};
            FMT_S:   imm = {{(XLEN-11){instr[31]}}, instr[30:25], instr[11:7]};
            FMT_B:   imm = {{(XLEN-12){instr[31]}}, instr[7], instr[30:25],
                            instr[11:8], 1'b0};
            FMT_U:   imm = {{(XLEN-31){instr[31]}}, instr[30:12], 12'b0};
            FMT_J:   imm = {{(XLEN-20){instr[31]}}, instr[19:12], instr[20],
                            instr[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

    assign illegal = (fmt == FMT_ILL);
    // LUI shares the U format but is not PC-relative
    assign pc_rel  = (fmt == FMT_B) || (fmt == FMT_J) || (w_opcode == OPC_AUIPC);

endmodule
`default_nettype wire

// File: rtl/imm_gen_stage.sv
`default_nettype none
// ============================================================================
//  Module      : imm_gen_stage
//  Description : Registered immediate-generation stage with a 2-entry skid
//                buffer behind a valid/ready handshake. Decode (and the
//                optional PC-relative add) happen at capture; outputs come
//                only from registers.
//  Ports       : clk, rst (async, active-high), flush
//                in_valid/in_ready/in_instr/in_pc  - upstream side
//                out_valid/out_ready               - downstream handshake
//                out_imm/out_fmt/out_illegal/out_target - registered results
//  Config      : IMMGEN_TARGET_EN - when defined, the PC adder and target
//                storage are built; otherwise out_target is tied to 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module imm_gen_stage
    import imm_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic            out_illegal,
    output logic [XLEN-1:0] out_target
);

    skid_state_t     r_state;
    skid_state_t     w_state_next;

    logic [2:0]      w_dec_fmt;
    logic [XLEN-1:0] w_dec_imm;
    logic            w_dec_illegal;
    logic            w_dec_pc_rel;

    logic            w_in_fire;
    logic            w_out_fire;
    logic            w_load_main;
    logic            w_load_skid;
    logic            w_promote;

    logic [XLEN-1:0] r_main_imm;
    logic [2:0]      r_main_fmt;
    logic            r_main_ill;
    logic [XLEN-1:0] r_skid_imm;
    logic [2:0]      r_skid_fmt;
    logic            r_skid_ill;

    imm_decode #(
        .XLEN (XLEN),
        .SHW  (SHW)
    ) u_decode (
        .instr   (in_instr),
        .fmt     (w_dec_fmt),
        .imm     (w_dec_imm),
        .illegal (w_dec_illegal),
        .pc_rel  (w_dec_pc_rel)
    );

    // Flush suppresses acceptance so a concurrent entry is not captured
    assign w_in_fire  = in_valid & in_ready & ~flush;
    assign w_out_fire = out_valid & out_ready;

    // New entry goes to main when main is free or being drained this cycle
    assign w_load_main = w_in_fire & ((r_state == SKID_EMPTY) ||
                                      ((r_state == SKID_ONE) & w_out_fire));
    assign w_load_skid = w_in_fire & (r_state == SKID_ONE) & ~w_out_fire;
    assign w_promote   = (r_state == SKID_TWO) & w_out_fire;

    // ---------------- state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= SKID_EMPTY;
        else
            r_state <= w_state_next;
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        w_state_next = r_state;
        if (flush) begin
            w_state_next = SKID_EMPTY;
        end else begin
            case (r_state)
                SKID_EMPTY: if (w_in_fire) w_state_next = SKID_ONE;
                SKID_ONE: begin
                    if (w_in_fire & ~w_out_fire)
                        w_state_next = SKID_TWO;
                    else if (~w_in_fire & w_out_fire)
                        w_state_next = SKID_EMPTY;
                end
                SKID_TWO:   if (w_out_fire) w_state_next = SKID_ONE;
                default:    w_state_next = SKID_EMPTY;
            endcase
        end
    end

    // ---------------- state outputs ----------------
    // in_ready comes from registered state only, never from out_ready
    always_comb begin
        out_valid = (r_state != SKID_EMPTY);
        in_ready  = (r_state != SKID_TWO);
    end

    // ---------------- entry storage ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_main_imm <= '0;
            r_main_fmt <= FMT_R;
            r_main_ill <= 1'b0;
            r_skid_imm <= '0;
            r_skid_fmt <= FMT_R;
            r_skid_ill <= 1'b0;
        end else if (flush) begin
            r_main_imm <= '0;
            r_main_fmt <= FMT_R;
            r_main_ill <= 1'b0;
            r_skid_imm <= '0;
            r_skid_fmt <= FMT_R;
            r_skid_ill <= 1'b0;
        end else begin
            if (w_load_main) begin
                r_main_imm <= w_dec_imm;
                r_main_fmt <= w_dec_fmt;
                r_main_ill <= w_dec_illegal;
            end else if (w_promote) begin
                r_main_imm <= r_skid_imm;
                r_main_fmt <= r_skid_fmt;
                r_main_ill <= r_skid_ill;
            end
            if (w_load_skid) begin
                r_skid_imm <= w_dec_imm;
                r_skid_fmt <= w_dec_fmt;
                r_skid_ill <= w_dec_illegal;
            end
        end
    end

    assign out_imm     = r_main_imm;
    assign out_fmt     = r_main_fmt;
    assign out_illegal = r_main_ill;

`ifdef IMMGEN_TARGET_EN
    logic [XLEN-1:0] w_new_target;
    logic [XLEN-1:0] r_main_tgt;
    logic [XLEN-1:0] r_skid_tgt;

    // Natural XLEN-bit wrap on the add
    assign w_new_target = w_dec_pc_rel ? (in_pc + w_dec_imm) : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_main_tgt <= '0;
            r_skid_tgt <= '0;
        end else if (flush) begin
            r_main_tgt <= '0;
            r_skid_tgt <= '0;
        end else begin
            if (w_load_main)
                r_main_tgt <= w_new_target;
            else if (w_promote)
                r_main_tgt <= r_skid_tgt;
            if (w_load_skid)
                r_skid_tgt <= w_new_target;
        end
    end

    assign out_target = r_main_tgt;
`else
    logic w_unused_target;

    assign w_unused_target = ^{in_pc, w_dec_pc_rel};
    assign out_target      = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_imm_gen_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imm_gen_stage
//  Description : Self-checking bench for imm_gen_stage. Drives an XLEN=32
//                and an XLEN=64 instance from shared controls, checks table
//                vectors, hand-written backpressure/flush/reset sequences and
//                a randomised stream against a queue-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_imm_gen_stage;
    import imm_pkg::*;

`ifdef IMMGEN_TARGET_EN
    localparam bit TGT_EN = 1'b1;
`else
    localparam bit TGT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic [31:0] in_instr;
    logic [31:0] pc32;
    logic [63:0] pc64;

    logic        rdy32, vld32, ill32;
    logic [31:0] imm32, tgt32;
    logic [2:0]  fmt32;
    logic        rdy64, vld64, ill64;
    logic [63:0] imm64, tgt64;
    logic [2:0]  fmt64;

    always #5 clk = ~clk;

    imm_gen_stage #(.XLEN(32)) dut32 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy32), .in_instr(in_instr), .in_pc(pc32),
        .out_valid(vld32), .out_ready(out_ready), .out_imm(imm32),
        .out_fmt(fmt32), .out_illegal(ill32), .out_target(tgt32)
    );

    imm_gen_stage #(.XLEN(64)) dut64 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy64), .in_instr(in_instr), .in_pc(pc64),
        .out_valid(vld64), .out_ready(out_ready), .out_imm(imm64),
        .out_fmt(fmt64), .out_illegal(ill64), .out_target(tgt64)
    );

    typedef struct {
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        ill;
        logic [63:0] tgt;
    } exp_t;

    typedef struct {
        logic [31:0] instr;
        logic [63:0] pc;
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic [63:0] tgt;
    } vec_t;

    int total = 0;
    int bad   = 0;

    exp_t q32[$];
    exp_t q64[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Reference: fields assembled arithmetically from the instruction bits
    function automatic exp_t ref_dec(input logic [31:0] ins, input logic [63:0] pc, input int xlen);
        exp_t        e;
        longint      v, iv, sv, bv, uv, jv, shv;
        logic [63:0] mask;
        bit          rel;
        mask = (xlen == 32) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
        iv  = longint'(ins[31:20]) - (ins[31] ? 4096 : 0);
        sv  = longint'(ins[31:25]) * 32 + longint'(ins[11:7]) - (ins[31] ? 4096 : 0);
        bv  = longint'(ins[7]) * 2048 + longint'(ins[30:25]) * 32
            + longint'(ins[11:8]) * 2 - (ins[31] ? 4096 : 0);
        uv  = longint'(ins[31:12]) * 4096 - (ins[31] ? 64'sd4294967296 : 64'sd0);
        jv  = longint'(ins[19:12]) * 4096 + longint'(ins[20]) * 2048
            + longint'(ins[30:21]) * 2 - (ins[31] ? 1048576 : 0);
        shv = longint'(ins[24:20]) + ((xlen == 64) ? 32 * longint'(ins[25]) : 0);
        v = 0;
        rel = 1'b0;
        e.fmt = FMT_ILL;
        case (ins[6:0])
            7'h13: begin
                if (ins[14:12] == 3'd1 || ins[14:12] == 3'd5) begin
                    e.fmt = FMT_ISH; v = shv;
                end else begin
                    e.fmt = FMT_I; v = iv;
                end
            end
            7'h03, 7'h67, 7'h0F, 7'h73: begin e.fmt = FMT_I; v = iv; end
            7'h23: begin e.fmt = FMT_S; v = sv; end
            7'h63: begin e.fmt = FMT_B; v = bv; rel = 1'b1; end
            7'h37: begin e.fmt = FMT_U; v = uv; end
            7'h17: begin e.fmt = FMT_U; v = uv; rel = 1'b1; end
            7'h6F: begin e.fmt = FMT_J; v = jv; rel = 1'b1; end
            7'h33: begin e.fmt = FMT_R; v = 0; end
            default: begin e.fmt = FMT_ILL; v = 0; end
        endcase
        e.imm = 64'(v) & mask;
        e.ill = (e.fmt == FMT_ILL);
        e.tgt = (rel && TGT_EN) ? ((pc + e.imm) & mask) : 64'h0;
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 12))
            0:  r[6:0] = 7'h13;
            1:  r[6:0] = 7'h03;
            2:  r[6:0] = 7'h67;
            3:  r[6:0] = 7'h0F;
            4:  r[6:0] = 7'h73;
            5:  r[6:0] = 7'h23;
            6:  r[6:0] = 7'h63;
            7:  r[6:0] = 7'h37;
            8:  r[6:0] = 7'h17;
            9:  r[6:0] = 7'h6F;
            10: r[6:0] = 7'h33;
            11: r[6:0] = 7'h7F;
            default: ;
        endcase
        return r;
    endfunction

    task automatic chk_out32(input string tag, input exp_t e);
        chk({tag, ".imm"}, {32'h0, imm32}, e.imm);
        chk({tag, ".fmt"}, {61'h0, fmt32}, {61'h0, e.fmt});
        chk({tag, ".ill"}, {63'h0, ill32}, {63'h0, e.ill});
        chk({tag, ".tgt"}, {32'h0, tgt32}, e.tgt);
    endtask

    task automatic chk_out64(input string tag, input exp_t e);
        chk({tag, ".imm"}, imm64, e.imm);
        chk({tag, ".fmt"}, {61'h0, fmt64}, {61'h0, e.fmt});
        chk({tag, ".ill"}, {63'h0, ill64}, {63'h0, e.ill});
        chk({tag, ".tgt"}, tgt64, e.tgt);
    endtask

    function automatic exp_t vec2exp(input vec_t v);
        exp_t e;
        e.imm = v.imm;
        e.fmt = v.fmt;
        e.ill = (v.fmt == FMT_ILL);
        e.tgt = TGT_EN ? v.tgt : 64'h0;
        return e;
    endfunction

    // Model update for one edge using the inputs currently driven
    task automatic model_step();
        bit fo, fi;
        fo = (q32.size() > 0) && out_ready;
        fi = in_valid && (q32.size() < 2);
        if (flush) q32.delete();
        else begin
            if (fo) void'(q32.pop_front());
            if (fi) q32.push_back(ref_dec(in_instr, {32'h0, pc32}, 32));
        end
        fo = (q64.size() > 0) && out_ready;
        fi = in_valid && (q64.size() < 2);
        if (flush) q64.delete();
        else begin
            if (fo) void'(q64.pop_front());
            if (fi) q64.push_back(ref_dec(in_instr, pc64, 64));
        end
    endtask

    task automatic model_check(input int cyc);
        string t;
        t = $sformatf("rnd%0d", cyc);
        chk({t, ".v32"}, {63'h0, vld32}, {63'h0, q32.size() > 0});
        chk({t, ".r32"}, {63'h0, rdy32}, {63'h0, q32.size() < 2});
        if (q32.size() > 0) chk_out32({t, ".d32"}, q32[0]);
        chk({t, ".v64"}, {63'h0, vld64}, {63'h0, q64.size() > 0});
        chk({t, ".r64"}, {63'h0, rdy64}, {63'h0, q64.size() < 2});
        if (q64.size() > 0) chk_out64({t, ".d64"}, q64[0]);
    endtask

    localparam logic [31:0] INS_A = 32'h0010_0093;  // addi x1,x0,1
    localparam logic [31:0] INS_B = 32'h0020_0093;  // addi x1,x0,2
    localparam logic [31:0] INS_C = 32'h0030_0093;  // addi x1,x0,3
    localparam logic [31:0] INS_D = 32'h0040_0093;  // addi x1,x0,4
    localparam logic [31:0] INS_E = 32'h0050_0093;  // addi x1,x0,5

    exp_t zero_e;
    vec_t t32[$];
    vec_t t64[$];

    initial begin
        zero_e = '{imm: 64'h0, fmt: FMT_R, ill: 1'b0, tgt: 64'h0};

        t32.push_back('{32'hFFF00093, 64'h0,   64'hFFFF_FFFF, FMT_I,   64'h0});
        t32.push_back('{32'h12345037, 64'h0,   64'h1234_5000, FMT_U,   64'h0});
        t32.push_back('{32'h40315093, 64'h0,   64'h3,         FMT_ISH, 64'h0});
        t32.push_back('{32'hFE000EE3, 64'h100, 64'hFFFF_FFFC, FMT_B,   64'hFC});
        t32.push_back('{32'hFE000EE3, 64'h0,   64'hFFFF_FFFC, FMT_B,   64'hFFFF_FFFC});
        t32.push_back('{32'h0000007F, 64'h40,  64'h0,         FMT_ILL, 64'h0});
        t32.push_back('{32'h00001017, 64'h10,  64'h1000,      FMT_U,   64'h1010});
        t32.push_back('{32'h0080006F, 64'h20,  64'h8,         FMT_J,   64'h28});
        t32.push_back('{32'hFE112E23, 64'h0,   64'hFFFF_FFFC, FMT_S,   64'h0});
        t32.push_back('{32'h002081B3, 64'h0,   64'h0,         FMT_R,   64'h0});
        t32.push_back('{32'h00452083, 64'h0,   64'h4,         FMT_I,   64'h0});
        t32.push_back('{32'hFFC080E7, 64'h40,  64'hFFFF_FFFC, FMT_I,   64'h0});

        t64.push_back('{32'h80000037, 64'h0, 64'hFFFF_FFFF_8000_0000, FMT_U,   64'h0});
        t64.push_back('{32'h02109093, 64'h0, 64'h21,                  FMT_ISH, 64'h0});
        t64.push_back('{32'h42105093, 64'h0, 64'h21,                  FMT_ISH, 64'h0});
        t64.push_back('{32'h00001017, 64'hFFFF_FFFF_FFFF_FFF0, 64'h1000, FMT_U, 64'h0FF0});
        t64.push_back('{32'hFE000EE3, 64'h0, 64'hFFFF_FFFF_FFFF_FFFC, FMT_B,
                        64'hFFFF_FFFF_FFFF_FFFC});

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = 32'h0; pc32 = 32'h0; pc64 = 64'h0;

        // ---------------- reset state ----------------
        @(negedge clk);
        chk("rst.v32", {63'h0, vld32}, 64'h0);
        chk("rst.r32", {63'h0, rdy32}, 64'h1);
        chk_out32("rst", zero_e);
        chk("rst.v64", {63'h0, vld64}, 64'h0);
        rst = 1'b0;

        // ---------------- table vectors, XLEN=32 ----------------
        foreach (t32[i]) begin
            in_valid = 1'b1; out_ready = 1'b1;
            in_instr = t32[i].instr; pc32 = t32[i].pc[31:0]; pc64 = t32[i].pc;
            @(negedge clk);
            chk($sformatf("t32_%0d.v", i), {63'h0, vld32}, 64'h1);
            chk_out32($sformatf("t32_%0d", i), vec2exp(t32[i]));
            in_valid = 1'b0;
            @(negedge clk);
            chk($sformatf("t32_%0d.drain", i), {63'h0, vld32}, 64'h0);
        end

        // ---------------- table vectors, XLEN=64 ----------------
        foreach (t64[i]) begin
            in_valid = 1'b1; out_ready = 1'b1;
            in_instr = t64[i].instr; pc32 = t64[i].pc[31:0]; pc64 = t64[i].pc;
            @(negedge clk);
            chk($sformatf("t64_%0d.v", i), {63'h0, vld64}, 64'h1);
            chk_out64($sformatf("t64_%0d", i), vec2exp(t64[i]));
            in_valid = 1'b0;
            @(negedge clk);
        end
        pc32 = 32'h0; pc64 = 64'h0;

        // ---------------- backpressure A, B, C ----------------
        out_ready = 1'b0; in_valid = 1'b1; in_instr = INS_A;
        @(negedge clk);
        chk("bp.a_valid", {63'h0, vld32}, 64'h1);
        chk("bp.a_ready", {63'h0, rdy32}, 64'h1);
        chk("bp.a_imm",   {32'h0, imm32}, 64'h1);
        in_instr = INS_B;
        @(negedge clk);
        chk("bp.b_ready", {63'h0, rdy32}, 64'h0);
        chk("bp.b_imm",   {32'h0, imm32}, 64'h1);
        in_instr = INS_C;
        @(negedge clk);
        chk("bp.c_ready", {63'h0, rdy32}, 64'h0);
        chk("bp.stall1",  {32'h0, imm32}, 64'h1);
        @(negedge clk);
        chk("bp.stall2",  {32'h0, imm32}, 64'h1);
        chk("bp.stall_v", {63'h0, vld32}, 64'h1);
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp.out_b",   {32'h0, imm32}, 64'h2);
        chk("bp.ready_b", {63'h0, rdy32}, 64'h1);
        @(negedge clk);
        chk("bp.out_c",   {32'h0, imm32}, 64'h3);
        chk("bp.v_c",     {63'h0, vld32}, 64'h1);
        in_valid = 1'b0;
        @(negedge clk);
        chk("bp.empty",   {63'h0, vld32}, 64'h0);

        // ---------------- flush in TWO ----------------
        out_ready = 1'b0; in_valid = 1'b1; in_instr = INS_A;
        @(negedge clk);
        in_instr = INS_B;
        @(negedge clk);
        chk("fl.two", {63'h0, rdy32}, 64'h0);
        flush = 1'b1; in_instr = INS_D;
        @(negedge clk);
        chk("fl.valid", {63'h0, vld32}, 64'h0);
        chk("fl.ready", {63'h0, rdy32}, 64'h1);
        chk("fl.imm",   {32'h0, imm32}, 64'h0);
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("fl.no_d",  {63'h0, vld32}, 64'h0);

        // ---------------- asynchronous reset in TWO ----------------
        in_valid = 1'b1; in_instr = INS_A;
        @(negedge clk);
        in_instr = INS_B;
        @(negedge clk);
        chk("ar.two", {63'h0, rdy32}, 64'h0);
        in_instr = INS_D;
        #2 rst = 1'b1;
        #1;
        chk("ar.valid", {63'h0, vld32}, 64'h0);
        chk("ar.ready", {63'h0, rdy32}, 64'h1);
        chk_out32("ar", zero_e);
        @(negedge clk);
        chk("ar.hold", {63'h0, vld32}, 64'h0);
        rst = 1'b0; out_ready = 1'b1; in_instr = INS_E;
        @(negedge clk);
        chk("ar.fresh_v",   {63'h0, vld32}, 64'h1);
        chk("ar.fresh_imm", {32'h0, imm32}, 64'h5);
        in_valid = 1'b0;
        @(negedge clk);
        chk("ar.drain", {63'h0, vld32}, 64'h0);

        // ---------------- randomised stream vs model ----------------
        q32.delete();
        q64.delete();
        for (int cyc = 0; cyc < 600; cyc++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 39) == 0);
            in_instr  = rand_instr();
            pc32      = $urandom;
            pc64      = {$urandom, $urandom};
            model_step();
            @(negedge clk);
            model_check(cyc);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/imm_gen_stage.md
# imm_gen_stage

Registered, parametrised immediate-generation stage for the SCPU datapath. Decodes the format directly from the 32-bit instruction opcode, so the external EXTOp select is no longer needed. Produces an XLEN-wide sign-extended immediate and, optionally, a PC-relative target. It sits between fetch/decode and execute behind a valid/ready handshake, with a 2-entry skid buffer so backpressure never drops or duplicates an instruction.

## Interface
- XLEN, 32: datapath width; legal values are 32 and 64.
- SHW, $clog2(XLEN): shift-amount width; 5 for XLEN=32, 6 for XLEN=64.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- flush  in  1  discard all buffered entries.
- in_valid  in  1  upstream entry valid.
- in_ready  out  1  stage can accept an entry this cycle.
- in_instr  in  32  instruction word.
- in_pc  in  XLEN  PC of the instruction.
- out_valid  out  1  output entry valid.
- out_ready  in  1  downstream accepts the entry.
- out_imm  out  XLEN  extended immediate.
- out_fmt  out  3  format code (imm_pkg).
- out_illegal  out  1  opcode is not recognised.
- out_target  out  XLEN  in_pc + imm for branch/JAL/AUIPC; 0 for all other formats.

## Operation
- Opcode in_instr[6:0] selects the format:
  - 0010011 with funct3 001/101 → ISH.
  - Any other 0010011, 0000011, 1100111, 0001111, 1110011 → I.
  - 0100011 → S.
  - 1100011 → B.
  - 0110111, 0010111 → U.
  - 1101111 → J.
  - 0110011 → R.
  - Anything else → ILL.
- Immediate per format:
  - I: sext(instr[31:20]).
  - ISH: zero-extended instr[20+SHW-1:20]. funct7/funct6 bits are not part of the immediate.
  - S: sext({instr[31:25], instr[11:7]}).
  - B: sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
  - U: sext({instr[31:12], 12'b0}). Sign-extends for XLEN=64.
  - J: sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
  - R and ILL: 0.
- out_illegal = (fmt == ILL).
- Target: in_pc + imm, modulo 2^XLEN (wraps, no overflow flag), for B, J, and U with opcode 0010111 only. Otherwise 0.
- Decode and add are computed at capture; only registered values drive the outputs.
- Skid buffer states:
  - EMPTY: out_valid=0, in_ready=1.
  - ONE: out_valid=1, in_ready=1.
  - TWO: out_valid=1, in_ready=0.
- Transitions (in_fire = in_valid & in_ready, out_fire = out_valid & out_ready):
  - EMPTY + in_fire → ONE.
  - ONE + in_fire & out_fire → ONE, main entry replaced.
  - ONE + in_fire & !out_fire → TWO, new entry stored in skid.
  - ONE + out_fire only → EMPTY.
  - TWO + out_fire → ONE, skid moves to main.
  - Otherwise hold.
- Ordering is strictly FIFO.
- flush has priority over everything: next state EMPTY, and in_valid is ignored that cycle.

## Timing
- Latency 1 cycle: an entry accepted at edge N is visible on out_* after edge N.
- Throughput: 1 entry per cycle when out_ready is held high.
- in_ready depends only on registered state; there is no combinational path from out_ready to in_ready.
- While out_valid=1 and out_ready=0, all out_* hold stable.
- Reset values: state EMPTY, out_valid 0, out_imm 0, out_fmt 0 (R), out_illegal 0, out_target 0, skid contents 0, in_ready 1.
- Reset mid-operation discards both entries immediately (asynchronous). in_valid is ignored while rst is high.
- Flush and reset take effect on the outputs at the next edge for flush and immediately for rst. No partial entry ever survives.

## Configuration
- IMMGEN_TARGET_EN defined: PC adder, target registers and in_pc capture are present; out_target behaves as specified above.
- IMMGEN_TARGET_EN undefined: no adder and no target/PC storage; out_target is tied to 0 and in_pc is unused. All other behaviour is identical.

## Structure
- Package imm_pkg holds:
  - format codes: FMT_R=0, FMT_I=1, FMT_ISH=2, FMT_S=3, FMT_B=4, FMT_U=5, FMT_J=6, FMT_ILL=7;
  - opcode constants;
  - the skid-state enum.
- Sub-module imm_decode is purely combinational: instr → {fmt, imm, illegal}, parametrised on XLEN. It is instantiated once, ahead of capture.
- imm_gen_stage owns the skid buffer, state machine and optional adder.

## Test plan
- XLEN=32, pc 0, single entries with out_ready=1:
  - 0xFFF00093 → imm 0xFFFFFFFF, fmt I.
  - 0x12345037 → imm 0x12345000, fmt U.
  - 0x40315093 → imm 3, fmt ISH.
- XLEN=32, IMMGEN_TARGET_EN defined: pc 0x100, instr 0xFE000EE3 → imm 0xFFFFFFFC, fmt B, target 0x000000FC. With pc 0x0 → target 0xFFFFFFFC (wrap).
- Backpressure:
  - out_ready=0; send A, B, C back-to-back → in_ready drops after B; C stays pending.
  - Raise out_ready → A, B, C emerge in order, each exactly once, with out_* stable while stalled.
- Flush in state TWO → out_valid 0 and in_ready 1 after the next edge; a concurrent in_valid entry is not accepted.
- Illegal and XLEN=64:
  - instr 0x0000007F → fmt ILL, out_illegal 1, imm 0, target 0.
  - XLEN=64, 0x8000_0037 → imm 0xFFFFFFFF80000000.
  - XLEN=64, slli with shamt 33 → imm 33.
- Assert rst mid-stream in state TWO → out_valid 0 immediately, all outputs 0. After release, a fresh entry passes with 1-cycle latency.
